// File: rtl/hazard_pkg.sv
// Shared types and defaults for the ID/EX hazard controller.
// The FSM tracks data-memory waits; ERROR is reached only by timeout.
package hazard_pkg;

  localparam int DEF_CNT_W       = 32;
  localparam int DEF_MEM_TIMEOUT = 15;
  localparam int WAIT_W          = 8;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } hz_state_t;

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
// It sticks at all-ones instead of wrapping.
module hazard_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_cnt <= '0;
    end else if (inc_i && (r_cnt != {WIDTH{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller beside the ID stage: load-use stall, branch flush,
// data-memory freeze with timeout, plus stall/flush performance counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             IDEX_MemRead_i,
  input  logic [4:0]       IDEX_RdAddr_i,
  input  logic [4:0]       ID_RS1Addr_i,
  input  logic [4:0]       ID_RS2Addr_i,
  input  logic             ID_RS1Used_i,
  input  logic             ID_RS2Used_i,
  input  logic             BranchTaken_i,
  input  logic             DMemBusy_i,
  output logic             PCWrite_o,
  output logic             IFIDWrite_o,
  output logic             IFIDFlush_o,
  output logic             IDEXBubble_o,
  output logic             PipeWrite_o,
  output logic             MemTimeout_o,
  output logic [CNT_W-1:0] StallCnt_o,
  output logic [CNT_W-1:0] FlushCnt_o
);

  localparam logic [WAIT_W-1:0] TIMEOUT_M1 = WAIT_W'(MEM_TIMEOUT - 1);

  hz_state_t         r_state;
  hz_state_t         w_state_nxt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_nxt;

  logic w_load_use;
  logic w_active;
  logic w_pc_we;
  logic w_ifid_we;
  logic w_flush;
  logic w_bubble;
  logic w_pipe_we;
  logic w_stall_inc;
  logic w_flush_inc;

  assign w_load_use = IDEX_MemRead_i && (IDEX_RdAddr_i != 5'd0) &&
                      ((ID_RS1Used_i && (ID_RS1Addr_i == IDEX_RdAddr_i)) ||
                       (ID_RS2Used_i && (ID_RS2Addr_i == IDEX_RdAddr_i)));

  // Gate for rules below the halt condition: in reset, stopped or in ERROR
  // nothing moves and nothing is counted.
  assign w_active = rst_i && start_i && (r_state != ERROR);

  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    case (r_state)
      RUN: begin
        if (start_i && DMemBusy_i) begin
          w_state_nxt = MEM_WAIT;
          w_wait_nxt  = '0;
        end
      end
      MEM_WAIT: begin
        if (!DMemBusy_i) begin
          w_state_nxt = RUN;
        end else if (start_i) begin
          w_wait_nxt = r_wait_cnt + 1'b1;
          if (r_wait_cnt == TIMEOUT_M1) begin
            w_state_nxt = ERROR;
          end
        end
      end
      ERROR: begin
        w_state_nxt = ERROR;
      end
      default: begin
        w_state_nxt = RUN;
        w_wait_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
    end
  end

  // Memory busy outranks load-use, which outranks a taken branch: a branch
  // seen during a stall re-resolves next cycle with forwarded operands.
  always_comb begin
    w_pc_we   = 1'b0;
    w_ifid_we = 1'b0;
    w_flush   = 1'b0;
    w_bubble  = 1'b0;
    w_pipe_we = 1'b0;
    if (w_active && !DMemBusy_i) begin
      if (w_load_use) begin
        w_bubble  = 1'b1;
        w_pipe_we = 1'b1;
      end else begin
        w_pc_we   = 1'b1;
        w_ifid_we = 1'b1;
        w_pipe_we = 1'b1;
        w_flush   = BranchTaken_i;
      end
    end
  end

  assign w_stall_inc = w_active && (DMemBusy_i || w_load_use);
  assign w_flush_inc = w_active && !DMemBusy_i && !w_load_use && BranchTaken_i;

  hazard_sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (w_stall_inc),
    .cnt_o (StallCnt_o)
  );

  hazard_sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (w_flush_inc),
    .cnt_o (FlushCnt_o)
  );

  assign PCWrite_o    = w_pc_we;
  assign IFIDWrite_o  = w_ifid_we;
  assign IFIDFlush_o  = w_flush;
  assign IDEXBubble_o = w_bubble;
  assign PipeWrite_o  = w_pipe_we;
  assign MemTimeout_o = (r_state == ERROR);

endmodule
